// File: rtl/conv_layer_sequencer.sv
// Multi-layer run controller for the conv AXIS wrapper: walks a descriptor table,
// resets the wrapper before each layer and gates the input stream while a layer runs.
module conv_layer_sequencer #(
   parameter int unsigned MAX_LAYERS = 16,
   parameter int unsigned LIDX_W     = 4,
   parameter int unsigned CH_IN_W    = 10,
   parameter int unsigned IM_W_W     = 10,
   parameter int unsigned NBLK_W     = 10,
   parameter int unsigned RST_CYC    = 4
) (
   input  logic                                   aclk,
   input  logic                                   areset,
   input  logic                                   cfg_we,
   input  logic [LIDX_W-1:0]                      cfg_addr,
   input  logic [2+CH_IN_W+IM_W_W+NBLK_W-1:0]     cfg_wdata,
   input  logic [LIDX_W:0]                        num_layers,
   input  logic                                   start,
   input  logic                                   abort,
   output logic                                   busy,
   output logic                                   done,
   output logic [LIDX_W-1:0]                      layer_idx,
   output logic [31:0]                            beat_cnt,
   output logic                                   conv_aresetn,
   output logic                                   conv_mode,
   output logic                                   max_mode,
   output logic [CH_IN_W-1:0]                     ch_in,
   output logic [IM_W_W-1:0]                      im_width,
   output logic [NBLK_W-1:0]                      num_blocks,
   input  logic                                   src_tvalid,
   output logic                                   src_tready,
   output logic                                   conv_s_tvalid,
   input  logic                                   conv_s_tready,
   input  logic                                   conv_finished,
   input  logic                                   conv_m_tvalid,
   input  logic                                   conv_m_tready,
   input  logic                                   conv_m_tlast
);

   localparam int unsigned CFG_W  = 2 + CH_IN_W + IM_W_W + NBLK_W;
   localparam int unsigned RCNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_CYC - 1);
   localparam logic [LIDX_W:0]   MAX_NUM  = (LIDX_W + 1)'(MAX_LAYERS);

   typedef enum logic [2:0] {StIdle, StLoad, StRst, StRun, StNext, StFin} state_e;

   state_e             state_q;
   logic [CFG_W-1:0]   table_q [MAX_LAYERS];
   logic [LIDX_W:0]    num_q;
   logic [RCNT_W-1:0]  rst_cnt_q;
   logic               fin_f_q;
   logic               last_f_q;
   logic               m_beat;
   logic               fin_now;
   logic               last_now;
   logic [LIDX_W:0]    num_clamped;

   assign m_beat      = conv_m_tvalid & conv_m_tready;
   assign fin_now     = fin_f_q | conv_finished;
   assign last_now    = last_f_q | (m_beat & conv_m_tlast);
   assign num_clamped = (num_layers > MAX_NUM) ? MAX_NUM : num_layers;

   assign src_tready    = conv_s_tready & (state_q == StRun);
   assign conv_s_tvalid = src_tvalid & (state_q == StRun);

   // Descriptor table survives reset and is write-protected while a run is active.
   always_ff @(posedge aclk) begin
      if (cfg_we && !busy) begin
         table_q[cfg_addr] <= cfg_wdata;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q      <= StIdle;
         busy         <= 1'b0;
         done         <= 1'b0;
         layer_idx    <= '0;
         beat_cnt     <= '0;
         conv_aresetn <= 1'b0;
         conv_mode    <= 1'b0;
         max_mode     <= 1'b0;
         ch_in        <= '0;
         im_width     <= '0;
         num_blocks   <= '0;
         num_q        <= '0;
         rst_cnt_q    <= '0;
         fin_f_q      <= 1'b0;
         last_f_q     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && busy) begin
            state_q      <= StIdle;
            busy         <= 1'b0;
            conv_aresetn <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start) begin
                     if (num_clamped != '0) begin
                        num_q     <= num_clamped;
                        layer_idx <= '0;
                        busy      <= 1'b1;
                        state_q   <= StLoad;
                     end else begin
                        done    <= 1'b1;
                        state_q <= StFin;
                     end
                  end
               end
               StLoad: begin
                  {conv_mode, max_mode, ch_in, im_width, num_blocks} <= table_q[layer_idx];
                  beat_cnt     <= '0;
                  fin_f_q      <= 1'b0;
                  last_f_q     <= 1'b0;
                  conv_aresetn <= 1'b0;
                  rst_cnt_q    <= '0;
                  state_q      <= StRst;
               end
               StRst: begin
                  if (rst_cnt_q == RST_LAST) begin
                     conv_aresetn <= 1'b1;
                     state_q      <= StRun;
                  end else begin
                     rst_cnt_q <= rst_cnt_q + RCNT_W'(1);
                  end
               end
               StRun: begin
                  if (m_beat) begin
                     beat_cnt <= beat_cnt + 32'd1;
                  end
                  fin_f_q  <= fin_now;
                  last_f_q <= last_now;
                  // Completion needs both events, in either order or together.
                  if (fin_now && last_now) begin
                     state_q <= StNext;
                  end
               end
               StNext: begin
                  if ({1'b0, layer_idx} == num_q - (LIDX_W + 1)'(1)) begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state_q <= StFin;
                  end else begin
                     layer_idx <= layer_idx + LIDX_W'(1);
                     state_q   <= StLoad;
                  end
               end
               StFin: begin
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer: a lock-step wrapper model driven from a
// layer vector table, with per-layer expectations queued at start and checked at layer end.
module tb_conv_layer_sequencer;

   localparam int RST_CYC = 4;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [4:0]  num_layers;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic [3:0]  layer_idx;
   logic [31:0] beat_cnt;
   logic        conv_aresetn;
   logic        conv_mode;
   logic        max_mode;
   logic [9:0]  ch_in;
   logic [9:0]  im_width;
   logic [9:0]  num_blocks;
   logic        src_tvalid;
   logic        src_tready;
   logic        conv_s_tvalid;
   logic        conv_s_tready;
   logic        conv_finished;
   logic        conv_m_tvalid;
   logic        conv_m_tready;
   logic        conv_m_tlast;
   logic [31:0] cfg_out;

   conv_layer_sequencer #(
      .RST_CYC (RST_CYC)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_we        (cfg_we),
      .cfg_addr      (cfg_addr),
      .cfg_wdata     (cfg_wdata),
      .num_layers    (num_layers),
      .start         (start),
      .abort         (abort),
      .busy          (busy),
      .done          (done),
      .layer_idx     (layer_idx),
      .beat_cnt      (beat_cnt),
      .conv_aresetn  (conv_aresetn),
      .conv_mode     (conv_mode),
      .max_mode      (max_mode),
      .ch_in         (ch_in),
      .im_width      (im_width),
      .num_blocks    (num_blocks),
      .src_tvalid    (src_tvalid),
      .src_tready    (src_tready),
      .conv_s_tvalid (conv_s_tvalid),
      .conv_s_tready (conv_s_tready),
      .conv_finished (conv_finished),
      .conv_m_tvalid (conv_m_tvalid),
      .conv_m_tready (conv_m_tready),
      .conv_m_tlast  (conv_m_tlast)
   );

   assign cfg_out = {conv_mode, max_mode, ch_in, im_width, num_blocks};

   always #5 aclk = ~aclk;

   // Layer vector: beats nb starting at RUN cycle bs (stalled before), conv_finished at
   // cycle fin; run_cyc is the expected number of RUN cycles, max(bs+nb-1, fin)+1.
   typedef struct {
      int nb;
      int bs;
      int fin;
      int run_cyc;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] cfg;
      int          beats;
   } exp_t;

   vec_t        vec [5];
   logic [31:0] desc [3];
   exp_t        sb [$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          done_seen = 0;
   int          gate_leak = 0;

   always @(negedge aclk) begin
      if (done === 1'b1) done_seen <= done_seen + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(negedge aclk);
   endtask

   task automatic clear_m();
      conv_m_tvalid = 1'b0;
      conv_m_tready = 1'b0;
      conv_m_tlast  = 1'b0;
      conv_finished = 1'b0;
   endtask

   // Waits (bounded) through LOAD/RST until RUN; counts reset-low cycles with new config.
   task automatic wait_run(input int idx, input logic [31:0] cfg);
      int low_cnt = 0;
      bit low_seen = 1'b0;
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (conv_aresetn === 1'b0) begin
            low_seen = 1'b1;
            if (cfg_out === cfg) low_cnt++;
         end else if (low_seen) begin
            ok = 1'b1;
            break;
         end
         if (src_tready !== 1'b0 || conv_s_tvalid !== 1'b0) gate_leak++;
         tick();
      end
      chk("run_entry", 64'(ok), 64'd1);
      chk("rst_low_cycles", 64'(low_cnt), 64'(RST_CYC));
      chk("layer_idx_run", 64'(layer_idx), 64'(idx));
   endtask

   task automatic layer(input int idx, input int v);
      int   open_cnt = 0;
      int   acc_cnt = 0;
      int   last;
      exp_t e;
      wait_run(idx, desc[idx]);
      last = vec[v].bs + vec[v].nb - 1;
      if (vec[v].fin > last) last = vec[v].fin;
      for (int c = 0; c <= last; c++) begin
         if (src_tready === 1'b1) open_cnt++;
         if (conv_s_tvalid === 1'b1 && conv_s_tready === 1'b1) acc_cnt++;
         conv_m_tvalid = (c < vec[v].bs + vec[v].nb);
         conv_m_tready = (c >= vec[v].bs);
         conv_m_tlast  = (c == vec[v].bs + vec[v].nb - 1);
         conv_finished = (c == vec[v].fin);
         tick();
      end
      clear_m();
      chk("run_cycles", 64'(open_cnt), 64'(vec[v].run_cyc));
      chk("src_accepted", 64'(acc_cnt), 64'(vec[v].run_cyc));
      if (sb.size() == 0) begin
         chk("sb_nonempty", 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         chk("next_layer_idx", 64'(layer_idx), 64'(e.idx));
         chk("beat_cnt", 64'(beat_cnt), 64'(e.beats));
         chk("config", 64'(cfg_out), 64'(e.cfg));
      end
      chk("busy_next", 64'(busy), 64'd1);
      chk("gate_next", 64'({src_tready, conv_s_tvalid}), 64'd0);
      tick();
   endtask

   task automatic do_run(input int num, input int vbase);
      int d0 = done_seen;
      for (int l = 0; l < num; l++) sb.push_back('{l, desc[l], vec[vbase + l].nb});
      num_layers = 5'(num);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int l = 0; l < num; l++) layer(l, vbase + l);
      chk("done_fin", 64'(done), 64'd1);
      chk("busy_fin", 64'(busy), 64'd0);
      tick();
      chk("done_after", 64'(done), 64'd0);
      chk("done_count", 64'(done_seen - d0), 64'd1);
   endtask

   initial begin
      int          d0;
      logic        aresetn_before;
      vec[0] = '{5, 0, 2, 5};
      vec[1] = '{7, 2, 8, 9};
      vec[2] = '{9, 0, 12, 13};
      vec[3] = '{3, 12, 4, 15};
      vec[4] = '{1, 0, 0, 1};
      desc[0] = {1'b0, 1'b1, 10'd16, 10'd28, 10'd7};
      desc[1] = {1'b1, 1'b0, 10'd64, 10'd14, 10'd3};
      desc[2] = {1'b1, 1'b1, 10'd128, 10'd7, 10'd1};

      areset = 1'b1;
      cfg_we = 1'b0;
      cfg_addr = '0;
      cfg_wdata = '0;
      num_layers = '0;
      start = 1'b0;
      abort = 1'b0;
      src_tvalid = 1'b1;
      conv_s_tready = 1'b1;
      clear_m();
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_layer_idx", 64'(layer_idx), 64'd0);
      chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
      chk("rst_aresetn", 64'(conv_aresetn), 64'd0);
      chk("rst_config", 64'(cfg_out), 64'd0);
      chk("rst_gate", 64'({src_tready, conv_s_tvalid}), 64'd0);
      tick();
      areset = 1'b0;
      tick();

      for (int i = 0; i < 3; i++) begin
         cfg_we = 1'b1;
         cfg_addr = 4'(i);
         cfg_wdata = desc[i];
         tick();
      end
      cfg_we = 1'b0;

      // Three layers of 5/7/9 beats; src_tvalid stays high throughout.
      do_run(3, 0);
      // finished well before tlast, then finished and tlast in the same cycle.
      do_run(2, 3);

      // Abort during layer 1.
      d0 = done_seen;
      sb.push_back('{0, desc[0], vec[0].nb});
      num_layers = 5'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      layer(0, 0);
      wait_run(1, desc[1]);
      conv_m_tvalid = 1'b1;
      conv_m_tready = 1'b1;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      clear_m();
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_aresetn", 64'(conv_aresetn), 64'd0);
      chk("abort_gate", 64'({src_tready, conv_s_tvalid}), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      repeat (3) tick();
      chk("abort_no_done", 64'(done_seen - d0), 64'd0);
      do_run(1, 0);

      // Zero layers: done one cycle after start, wrapper reset untouched.
      aresetn_before = conv_aresetn;
      d0 = done_seen;
      num_layers = 5'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_aresetn_a", 64'(conv_aresetn), 64'(aresetn_before));
      tick();
      chk("zero_done_after", 64'(done), 64'd0);
      chk("zero_aresetn_b", 64'(conv_aresetn), 64'(aresetn_before));
      chk("zero_done_count", 64'(done_seen - d0), 64'd1);

      // Table write attempted while busy must be ignored.
      sb.push_back('{0, desc[0], vec[4].nb});
      num_layers = 5'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_we = 1'b1;
      cfg_addr = 4'd0;
      cfg_wdata = 32'hdead_beef;
      tick();
      cfg_we = 1'b0;
      layer(0, 4);
      chk("we_run_done", 64'(done), 64'd1);
      tick();
      do_run(1, 0);

      // Asynchronous reset in the middle of layer 1.
      sb.push_back('{0, desc[0], vec[0].nb});
      num_layers = 5'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      layer(0, 0);
      wait_run(1, desc[1]);
      conv_m_tvalid = 1'b1;
      conv_m_tready = 1'b1;
      repeat (3) tick();
      chk("pre_reset_beats", 64'(beat_cnt), 64'd3);
      #2 areset = 1'b1;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_layer_idx", 64'(layer_idx), 64'd0);
      chk("arst_beat_cnt", 64'(beat_cnt), 64'd0);
      chk("arst_aresetn", 64'(conv_aresetn), 64'd0);
      chk("arst_config", 64'(cfg_out), 64'd0);
      chk("arst_gate", 64'({src_tready, conv_s_tvalid}), 64'd0);
      clear_m();
      tick();
      areset = 1'b0;
      tick();
      do_run(3, 0);

      chk("gate_closed_outside_run", 64'(gate_leak), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
